// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Purpose:
//   Turns single-cycle event strobes into visible fixed-width pulses. Each
//   accepted event produces exactly HIGH_CYCLES cycles of pulse_out=1. These are
//   followed by GAP_CYCLES cycles of pulse_out=0, so back-to-back events stay
//   distinguishable on an LED or a counter display.
//
// Parameters:
//   HIGH_CYCLES  output high time in clk cycles (>= 1)
//   GAP_CYCLES   forced low time after each pulse (>= 1)
//   PEND_W       width of the pending-event counter (saturates at 2**PEND_W-1)
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   pulse_in   in   1       event input; every cycle sampled high is one event
//   pulse_out  out  1       stretched pulse, registered
//   busy       out  1       high while a pulse or its gap is in progress
//   pending    out  PEND_W  queued events not yet replayed
//   overflow   out  1       one-cycle strobe per event that is lost
//
// Configuration macro:
//   PULSE_STRETCH_QUEUE_EN
//     Defined:   events seen while busy are counted in 'pending' and replayed
//                back-to-back. When the counter is full, further events are
//                lost and each lost event strobes 'overflow'.
//     Undefined: events seen while busy are dropped, each drop strobes
//                'overflow', and 'pending' is tied to zero.
//   In both builds, an event on the final gap edge starts the next pulse
//   directly, with no idle cycle in between.
// -----------------------------------------------------------------------------
module pulse_stretcher #(
    parameter int unsigned HIGH_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    // One counter serves both phases, so it is sized for the longer one.
    localparam int unsigned MAX_CYCLES = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;

    // Phase-completion flags for the current cycle.
    logic high_done;
    logic gap_done;
    // An event that arrives while a pulse or gap is running, but not on the
    // final gap edge. An event on the final gap edge is consumed directly by
    // the GAP->HIGH transition and is never queued or dropped.
    logic busy_evt;
    // A queued event is waiting to be replayed when the gap ends.
    logic replay_ok;

    assign high_done = (state_q == ST_HIGH) && (cnt_q == HIGH_LAST);
    assign gap_done  = (state_q == ST_GAP)  && (cnt_q == GAP_LAST);
    assign busy_evt  = pulse_in && (state_q != ST_IDLE) && !gap_done;

    // -------------------------------------------------------------------------
    // Sequencing FSM: IDLE -> HIGH -> GAP -> (HIGH | IDLE)
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end
            end

            ST_HIGH: begin
                if (high_done) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_GAP: begin
                if (gap_done) begin
                    // A same-edge event or a queued event restarts the pulse
                    // immediately. Otherwise the stretcher returns to idle.
                    state_d = (pulse_in || replay_ok) ? ST_HIGH : ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The outputs are decoded from the next state, so they change on the
        // same edge as the state and stay glitch-free registers.
        pulse_d = (state_d == ST_HIGH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Event accounting while busy
    // -------------------------------------------------------------------------
`ifdef PULSE_STRETCH_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0] pending_q, pending_d;

    assign replay_ok = (pending_q != '0);

    always_comb begin
        pending_d  = pending_q;
        overflow_d = 1'b0;

        if (busy_evt) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (gap_done && !pulse_in && replay_ok) begin
            // A replay consumes one queued event. If a fresh event arrives on
            // this edge, that event starts the pulse instead, and the count
            // is left unchanged: the queued event is still waiting.
            pending_d = pending_q - PEND_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`else
    assign replay_ok = 1'b0;

    always_comb begin
        overflow_d = busy_evt;
    end

    assign pending = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

`ifndef SYNTHESIS
    // A pulse or a lost event can only be reported while the block is busy.
    a_pulse_implies_busy : assert property (
        @(posedge clk) disable iff (rst) pulse_out |-> busy
    );
    a_overflow_implies_busy : assert property (
        @(posedge clk) disable iff (rst) overflow |-> busy
    );
`endif

endmodule
